// File: rtl/instr_mem_fetch_pkg.sv
// Shared constants, default program image and FSM state type for the
// instruction memory fetch block.
package instr_mem_pkg;

  localparam logic [7:0] NOP_CODE = '0;

  // Default boot program: Mov R5,R10 / Mov R10,R6 / Mov R6,R5
  localparam logic [7:0] DEFAULT_PROG [3] = '{8'h5A, 8'hA6, 8'h65};

  typedef enum logic {
    BOOT,
    RUN
  } state_t;

  function automatic logic [7:0] default_image(input int unsigned idx);
    case (idx)
      0:       return DEFAULT_PROG[0];
      1:       return DEFAULT_PROG[1];
      2:       return DEFAULT_PROG[2];
      default: return NOP_CODE;
    endcase
  endfunction

endpackage

// File: rtl/instr_mem_fetch_if.sv
// Fetch and program-write bus between the sequencer and instruction memory.
interface instr_mem_fetch_if #(
  parameter int IW = 8,
  parameter int AW = 8
);

  logic          fetch_req;
  logic [AW-1:0] fetch_pc;
  logic          fetch_ready;
  logic          instr_valid;
  logic [IW-1:0] instr_code;
  logic          instr_fault;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic          prog_ack;
  logic          boot_done;

  modport master (
    output fetch_req, fetch_pc, prog_we, prog_addr, prog_data,
    input  fetch_ready, instr_valid, instr_code, instr_fault, prog_ack, boot_done
  );

  modport slave (
    input  fetch_req, fetch_pc, prog_we, prog_addr, prog_data,
    output fetch_ready, instr_valid, instr_code, instr_fault, prog_ack, boot_done
  );

endinterface

// File: rtl/instr_mem_fetch_array.sv
// DEPTH x IW storage with one synchronous write and one synchronous read
// port. No reset: contents survive reset and are reloaded by the boot FSM.
module instr_mem_array #(
  parameter int IW    = 8,
  parameter int DEPTH = 16,
  parameter int AWI   = 4
) (
  input  logic           clk,
  input  logic           we,
  input  logic [AWI-1:0] waddr,
  input  logic [IW-1:0]  wdata,
  input  logic           re,
  input  logic [AWI-1:0] raddr,
  output logic [IW-1:0]  rdata
);

  logic [IW-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port; rdata holds between reads
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem_fetch.sv
// Loadable instruction memory: boots a default image into every word after
// reset, then serves 1-cycle-latency fetches and run-time program writes.
module instr_mem_fetch
  import instr_mem_pkg::*;
#(
  parameter int IW    = 8,
  parameter int AW    = 8,
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  instr_mem_fetch_if.slave   bus
);

  localparam int AWI = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] boot_cnt;
  logic          valid_r;
  logic          fault_r;
  logic          ack_r;
  logic          boot_done_r;
  logic          last_oor;
  logic [IW-1:0] rd_data;

  logic          fetch_in_range;
  logic          prog_in_range;
  logic          ready;
  logic          fetch_acc;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [IW-1:0] wr_data;

  assign fetch_in_range = {1'b0, bus.fetch_pc}  < DEPTH_W;
  assign prog_in_range  = {1'b0, bus.prog_addr} < DEPTH_W;
  assign ready          = (state == RUN) && !bus.prog_we;
  assign fetch_acc      = bus.fetch_req && ready;

  // Write-port mux: boot loader owns the port in BOOT, program port in RUN
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = boot_cnt;
    wr_data = IW'(default_image(32'(boot_cnt)));
    if (state == BOOT) begin
      wr_en = 1'b1;
    end else if (bus.prog_we && prog_in_range) begin
      wr_en   = 1'b1;
      wr_addr = bus.prog_addr;
      wr_data = bus.prog_data;
    end
  end

  instr_mem_array #(
    .IW    (IW),
    .DEPTH (DEPTH),
    .AWI   (AWI)
  ) u_array (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr[AWI-1:0]),
    .wdata (wr_data),
    .re    (fetch_acc && fetch_in_range),
    .raddr (bus.fetch_pc[AWI-1:0]),
    .rdata (rd_data)
  );

  // Boot/run FSM with registered handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      boot_cnt    <= '0;
      valid_r     <= 1'b0;
      fault_r     <= 1'b0;
      ack_r       <= 1'b0;
      boot_done_r <= 1'b0;
      last_oor    <= 1'b1;
    end else begin
      case (state)
        BOOT: begin
          valid_r <= 1'b0;
          fault_r <= 1'b0;
          ack_r   <= 1'b0;
          if (boot_cnt == LAST) begin
            state       <= RUN;
            boot_done_r <= 1'b1;
          end else begin
            boot_cnt <= boot_cnt + 1'b1;
          end
        end
        RUN: begin
          valid_r <= fetch_acc;
          fault_r <= fetch_acc && !fetch_in_range;
          ack_r   <= bus.prog_we && prog_in_range;
          if (fetch_acc) last_oor <= !fetch_in_range;
        end
        default: state <= BOOT;
      endcase
    end
  end

  // Code comes from the array's read register; an out-of-range (or reset)
  // last fetch forces NOP, and both sources hold while no fetch is accepted.
  assign bus.instr_code  = last_oor ? IW'(NOP_CODE) : rd_data;
  assign bus.instr_valid = valid_r;
  assign bus.instr_fault = fault_r;
  assign bus.prog_ack    = ack_r;
  assign bus.boot_done   = boot_done_r;
  assign bus.fetch_ready = ready;

endmodule
